// File: rtl/pipe_perf_monitor_if.sv
// pipe_perf_monitor_if: event, control and read-port signals between the CPU side and the performance monitor.
interface pipe_perf_monitor_if #(parameter int CNT_W = 32);
  logic start_i, stall_i, jump_i, branch_i, flush_i, retire_i, clear_i, rd_req_i;
  logic [1:0] rd_sel_i;
  logic rd_ack_o, running_o, done_o, overflow_o;
  logic [CNT_W-1:0] rd_data_o;
  modport master (
    output start_i, stall_i, jump_i, branch_i, flush_i, retire_i, clear_i, rd_req_i, rd_sel_i,
    input  rd_ack_o, rd_data_o, running_o, done_o, overflow_o
  );
  modport slave (
    input  start_i, stall_i, jump_i, branch_i, flush_i, retire_i, clear_i, rd_req_i, rd_sel_i,
    output rd_ack_o, rd_data_o, running_o, done_o, overflow_o
  );
endinterface

// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: saturating cycle/stall/flush/retire counters with a run budget and a req/ack read port.
module pipe_perf_monitor #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 30
) (
  input logic              clk_i,
  input logic              rst_i,
  pipe_perf_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt [4];
  logic [CNT_W-1:0] data_q;
  logic [3:0]       ev, sat;
  logic             ack_q, ovf_q, take, budget_hit;
  // counter index order matches rd_sel: cycle, stall, flush, retire
  assign ev = {bus.retire_i, bus.flush_i, bus.stall_i & ~bus.jump_i & ~bus.branch_i, 1'b1}
              & {4{state == RUN}};
  assign take = bus.rd_req_i & ~ack_q;
  assign budget_hit = (MAX_CYCLES != 0) && (64'(cnt[0]) + 64'd1 == 64'(MAX_CYCLES));
  always_comb begin
    for (int i = 0; i < 4; i++) sat[i] = &cnt[i];
  end
  always_comb begin
    state_nxt = state;
    if (bus.clear_i)
      state_nxt = (state == RUN || (state == IDLE && bus.start_i)) ? RUN : IDLE;
    else if (state == IDLE)
      state_nxt = bus.start_i ? RUN : IDLE;
    else if (state == RUN)
      state_nxt = budget_hit ? DONE : bus.start_i ? RUN : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      ovf_q  <= 1'b0;
      ack_q  <= 1'b0;
      data_q <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      state  <= state_nxt;
      ack_q  <= take;
      data_q <= take ? cnt[bus.rd_sel_i] : '0;
      if (bus.clear_i) begin
        ovf_q <= 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
        ovf_q <= ovf_q | |(ev & sat);
        for (int i = 0; i < 4; i++) cnt[i] <= cnt[i] + CNT_W'(ev[i] & ~sat[i]);
      end
    end
  end
  assign bus.rd_ack_o   = ack_q;
  assign bus.rd_data_o  = data_q;
  assign bus.running_o  = state == RUN;
  assign bus.done_o     = state == DONE;
  assign bus.overflow_o = ovf_q;
endmodule
